// File: rtl/ervp_index2onehot_stream.sv
// ---------------------------------------------------------------------------
// ervp_index2onehot_stream
//
// Streaming, registered index-to-onehot decoder. Each accepted input beat
// carries an index that is decoded into a NUM_DATA-wide onehot vector. With
// ACCUM_EN=0 every beat produces one output word. With ACCUM_EN=1 beats are
// ORed into an accumulator until a beat flagged in_last closes the word, so
// the output becomes a multi-hot mask. Each output word also reports how many
// beats were merged into it (saturating) and whether any of those beats
// carried an out-of-range index.
//
// Ports
//   clk         clock, all state updates on the rising edge
//   rstnn       asynchronous active-low reset
//   clear       synchronous flush of accumulator and output, highest priority
//   in_valid    input beat valid
//   in_ready    input beat accepted when in_valid && in_ready
//   in_index    index to decode (full width compared, never truncated)
//   in_last     closes the current word (ignored when ACCUM_EN=0)
//   out_valid   output word valid
//   out_ready   consumer ready
//   out_onehot  decoded onehot / multi-hot vector
//   out_count   number of beats merged into the word, saturating
//   out_error   at least one merged beat had an index >= NUM_DATA
//   busy        accumulator non-empty or out_valid asserted
// ---------------------------------------------------------------------------
module ervp_index2onehot_stream #(
    parameter int NUM_DATA = 8,
    parameter int BW_INDEX = 8,
    parameter int ACCUM_EN = 0,
    parameter int BW_COUNT = 4
) (
    input  logic                clk,
    input  logic                rstnn,
    input  logic                clear,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BW_INDEX-1:0] in_index,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NUM_DATA-1:0] out_onehot,
    output logic [BW_COUNT-1:0] out_count,
    output logic                out_error,
    output logic                busy
);

    // Accumulator FSM encoding
    localparam logic [0:0] ACC_EMPTY   = 1'b0;
    localparam logic [0:0] ACC_PARTIAL = 1'b1;

    // Index comparisons are done at a width that can hold both the full index
    // and any bit position, so large indices never alias onto valid bits.
    localparam int BW_CMP = (BW_INDEX > 32) ? BW_INDEX : 32;
    localparam logic [BW_CMP-1:0] NUM_DATA_CMP = BW_CMP'(NUM_DATA);

    localparam logic [BW_COUNT-1:0] CNT_ZERO = {BW_COUNT{1'b0}};
    localparam logic [BW_COUNT-1:0] CNT_MAX  = {BW_COUNT{1'b1}};
    localparam logic [BW_COUNT-1:0] CNT_ONE  = BW_COUNT'(1);
    localparam logic [NUM_DATA-1:0] VEC_ZERO = {NUM_DATA{1'b0}};

    localparam logic ACCUM_ON = (ACCUM_EN != 0);

    // -----------------------------------------------------------------------
    // Helper functions
    // -----------------------------------------------------------------------

    // Full-width compare of the index against every bit position. A single
    // output bit has only one possible meaning, so it is always set.
    function automatic logic [NUM_DATA-1:0] decode_index(input logic [BW_INDEX-1:0] idx);
        logic [BW_CMP-1:0]   idx_ext;
        logic [NUM_DATA-1:0] vec;
        idx_ext = BW_CMP'(idx);
        vec     = VEC_ZERO;
        if (NUM_DATA == 1) begin
            vec = {NUM_DATA{1'b1}};
        end else begin
            for (int i = 0; i < NUM_DATA; i++) begin
                vec[i] = (idx_ext == BW_CMP'(i));
            end
        end
        return vec;
    endfunction

    // Out-of-range flag; never raised for a single-bit output.
    function automatic logic index_out_of_range(input logic [BW_INDEX-1:0] idx);
        logic [BW_CMP-1:0] idx_ext;
        logic              oor;
        idx_ext = BW_CMP'(idx);
        if (NUM_DATA == 1) begin
            oor = 1'b0;
        end else begin
            oor = (idx_ext >= NUM_DATA_CMP);
        end
        return oor;
    endfunction

    // Saturating increment: clamps at all-ones instead of wrapping.
    function automatic logic [BW_COUNT-1:0] sat_inc(input logic [BW_COUNT-1:0] cnt);
        logic [BW_COUNT-1:0] res;
        if (cnt == CNT_MAX) begin
            res = CNT_MAX;
        end else begin
            res = cnt + CNT_ONE;
        end
        return res;
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [0:0]          state_r;
    logic [NUM_DATA-1:0] acc_vec_r;
    logic [BW_COUNT-1:0] acc_cnt_r;
    logic                acc_err_r;
    logic                out_valid_r;
    logic [NUM_DATA-1:0] out_vec_r;
    logic [BW_COUNT-1:0] out_cnt_r;
    logic                out_err_r;
    logic                busy_r;

    logic [0:0]          state_nxt_s;
    logic [NUM_DATA-1:0] acc_vec_nxt_s;
    logic [BW_COUNT-1:0] acc_cnt_nxt_s;
    logic                acc_err_nxt_s;
    logic                out_valid_nxt_s;
    logic [NUM_DATA-1:0] out_vec_nxt_s;
    logic [BW_COUNT-1:0] out_cnt_nxt_s;
    logic                out_err_nxt_s;
    logic                busy_nxt_s;

    logic                in_ready_s;
    logic                accept_s;
    logic                eff_last_s;
    logic [NUM_DATA-1:0] dec_vec_s;
    logic                dec_err_s;
    logic [NUM_DATA-1:0] merged_vec_s;
    logic [BW_COUNT-1:0] merged_cnt_s;
    logic                merged_err_s;

    // Handshake, decode and merge of the current beat with the accumulator
    always_comb begin
        // A new beat may enter whenever the output slot is free or being
        // drained this cycle; clear blocks acceptance for its cycle.
        in_ready_s   = !clear && (!out_valid_r || out_ready);
        accept_s     = in_valid && in_ready_s;
        eff_last_s   = ACCUM_ON ? in_last : 1'b1;
        dec_vec_s    = decode_index(in_index);
        dec_err_s    = index_out_of_range(in_index);
        // In ACC_EMPTY the accumulator is all zero, so the same merge serves
        // both the first beat of a word and any later one.
        merged_vec_s = acc_vec_r | dec_vec_s;
        merged_cnt_s = sat_inc(acc_cnt_r);
        merged_err_s = acc_err_r | dec_err_s;
    end

    // Next-state computation for FSM, accumulator and output register
    always_comb begin
        state_nxt_s     = state_r;
        acc_vec_nxt_s   = acc_vec_r;
        acc_cnt_nxt_s   = acc_cnt_r;
        acc_err_nxt_s   = acc_err_r;
        out_valid_nxt_s = out_valid_r;
        out_vec_nxt_s   = out_vec_r;
        out_cnt_nxt_s   = out_cnt_r;
        out_err_nxt_s   = out_err_r;

        if (clear) begin
            state_nxt_s     = ACC_EMPTY;
            acc_vec_nxt_s   = VEC_ZERO;
            acc_cnt_nxt_s   = CNT_ZERO;
            acc_err_nxt_s   = 1'b0;
            out_valid_nxt_s = 1'b0;
            out_vec_nxt_s   = VEC_ZERO;
            out_cnt_nxt_s   = CNT_ZERO;
            out_err_nxt_s   = 1'b0;
        end else begin
            // Drain the output slot on a completed transfer; a last beat
            // accepted in the same cycle refills it below without a bubble.
            if (out_valid_r && out_ready) begin
                out_valid_nxt_s = 1'b0;
            end else begin
                out_valid_nxt_s = out_valid_r;
            end

            if (accept_s && eff_last_s) begin
                out_valid_nxt_s = 1'b1;
                out_vec_nxt_s   = merged_vec_s;
                out_cnt_nxt_s   = merged_cnt_s;
                out_err_nxt_s   = merged_err_s;
                acc_vec_nxt_s   = VEC_ZERO;
                acc_cnt_nxt_s   = CNT_ZERO;
                acc_err_nxt_s   = 1'b0;
            end else if (accept_s) begin
                acc_vec_nxt_s   = merged_vec_s;
                acc_cnt_nxt_s   = merged_cnt_s;
                acc_err_nxt_s   = merged_err_s;
            end else begin
                acc_vec_nxt_s   = acc_vec_r;
                acc_cnt_nxt_s   = acc_cnt_r;
                acc_err_nxt_s   = acc_err_r;
            end

            case (state_r)
                ACC_EMPTY: begin
                    if (accept_s && !eff_last_s) begin
                        state_nxt_s = ACC_PARTIAL;
                    end else begin
                        state_nxt_s = ACC_EMPTY;
                    end
                end
                ACC_PARTIAL: begin
                    if (accept_s && eff_last_s) begin
                        state_nxt_s = ACC_EMPTY;
                    end else begin
                        state_nxt_s = ACC_PARTIAL;
                    end
                end
                default: begin
                    state_nxt_s = ACC_EMPTY;
                end
            endcase
        end

        // busy is registered from the next state so it tracks the flops exactly
        busy_nxt_s = (state_nxt_s == ACC_PARTIAL) || out_valid_nxt_s;
    end

    // State registers; reset discards any partial or pending word at once
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state_r     <= ACC_EMPTY;
            acc_vec_r   <= VEC_ZERO;
            acc_cnt_r   <= CNT_ZERO;
            acc_err_r   <= 1'b0;
            out_valid_r <= 1'b0;
            out_vec_r   <= VEC_ZERO;
            out_cnt_r   <= CNT_ZERO;
            out_err_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            acc_vec_r   <= acc_vec_nxt_s;
            acc_cnt_r   <= acc_cnt_nxt_s;
            acc_err_r   <= acc_err_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            out_vec_r   <= out_vec_nxt_s;
            out_cnt_r   <= out_cnt_nxt_s;
            out_err_r   <= out_err_nxt_s;
            busy_r      <= busy_nxt_s;
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_r;
    assign out_onehot = out_vec_r;
    assign out_count  = out_cnt_r;
    assign out_error  = out_err_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_ervp_index2onehot_stream.sv
// Directed bench for ervp_index2onehot_stream. Three instances:
//   A: NUM_DATA=8, ACCUM_EN=0, BW_COUNT=4  (per-beat decode)
//   B: NUM_DATA=6, ACCUM_EN=1, BW_COUNT=2  (accumulate, range, saturation,
//      backpressure, clear, async reset)
//   C: NUM_DATA=1, ACCUM_EN=1, BW_COUNT=4  (single-bit output)
module tb_ervp_index2onehot_stream;

    logic clk;
    logic rstnn;

    logic       a_clear, a_in_valid, a_in_last, a_out_ready;
    logic [7:0] a_in_index;
    logic       a_in_ready, a_out_valid, a_out_error, a_busy;
    logic [7:0] a_out_onehot;
    logic [3:0] a_out_count;

    logic       b_clear, b_in_valid, b_in_last, b_out_ready;
    logic [7:0] b_in_index;
    logic       b_in_ready, b_out_valid, b_out_error, b_busy;
    logic [5:0] b_out_onehot;
    logic [1:0] b_out_count;

    logic       c_clear, c_in_valid, c_in_last, c_out_ready;
    logic [7:0] c_in_index;
    logic       c_in_ready, c_out_valid, c_out_error, c_busy;
    logic [0:0] c_out_onehot;
    logic [3:0] c_out_count;

    int n_checks = 0;
    int n_errors = 0;

    ervp_index2onehot_stream #(.NUM_DATA(8), .BW_INDEX(8), .ACCUM_EN(0), .BW_COUNT(4)) dut_a (
        .clk(clk), .rstnn(rstnn), .clear(a_clear),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_index(a_in_index), .in_last(a_in_last),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_onehot(a_out_onehot),
        .out_count(a_out_count), .out_error(a_out_error), .busy(a_busy)
    );

    ervp_index2onehot_stream #(.NUM_DATA(6), .BW_INDEX(8), .ACCUM_EN(1), .BW_COUNT(2)) dut_b (
        .clk(clk), .rstnn(rstnn), .clear(b_clear),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_index(b_in_index), .in_last(b_in_last),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_onehot(b_out_onehot),
        .out_count(b_out_count), .out_error(b_out_error), .busy(b_busy)
    );

    ervp_index2onehot_stream #(.NUM_DATA(1), .BW_INDEX(8), .ACCUM_EN(1), .BW_COUNT(4)) dut_c (
        .clk(clk), .rstnn(rstnn), .clear(c_clear),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_index(c_in_index), .in_last(c_in_last),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_onehot(c_out_onehot),
        .out_count(c_out_count), .out_error(c_out_error), .busy(c_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic v, input logic [7:0] oh,
                         input logic [3:0] cnt, input logic err, input logic bsy);
        chk({tag, ".valid"},  32'(a_out_valid),  32'(v));
        chk({tag, ".onehot"}, 32'(a_out_onehot), 32'(oh));
        chk({tag, ".count"},  32'(a_out_count),  32'(cnt));
        chk({tag, ".error"},  32'(a_out_error),  32'(err));
        chk({tag, ".busy"},   32'(a_busy),       32'(bsy));
    endtask

    task automatic chk_b(input string tag, input logic v, input logic [5:0] oh,
                         input logic [1:0] cnt, input logic err, input logic bsy);
        chk({tag, ".valid"},  32'(b_out_valid),  32'(v));
        chk({tag, ".onehot"}, 32'(b_out_onehot), 32'(oh));
        chk({tag, ".count"},  32'(b_out_count),  32'(cnt));
        chk({tag, ".error"},  32'(b_out_error),  32'(err));
        chk({tag, ".busy"},   32'(b_busy),       32'(bsy));
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one B beat (applied for the next edge).
    task automatic b_beat(input logic [7:0] idx, input logic last);
        b_in_valid = 1'b1;
        b_in_index = idx;
        b_in_last  = last;
    endtask

    initial begin
        rstnn = 1'b0;
        a_clear = 1'b0; a_in_valid = 1'b0; a_in_last = 1'b0; a_out_ready = 1'b1; a_in_index = 8'd0;
        b_clear = 1'b0; b_in_valid = 1'b0; b_in_last = 1'b0; b_out_ready = 1'b1; b_in_index = 8'd0;
        c_clear = 1'b0; c_in_valid = 1'b0; c_in_last = 1'b0; c_out_ready = 1'b1; c_in_index = 8'd0;

        tick();
        tick();
        chk_a("a_reset", 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
        chk_b("b_reset", 1'b0, 6'h00, 2'd0, 1'b0, 1'b0);
        rstnn = 1'b1;
        #1;
        chk("a_ready_after_reset", 32'(a_in_ready), 32'd1);
        chk("b_ready_after_reset", 32'(b_in_ready), 32'd1);

        // ---------------- A: one word per beat ----------------
        a_in_valid = 1'b1; a_in_index = 8'd0;
        tick();
        chk_a("a_idx0", 1'b1, 8'h01, 4'd1, 1'b0, 1'b1);
        chk("a_ready0", 32'(a_in_ready), 32'd1);
        a_in_index = 8'd3;
        tick();
        chk_a("a_idx3", 1'b1, 8'h08, 4'd1, 1'b0, 1'b1);
        chk("a_ready3", 32'(a_in_ready), 32'd1);
        a_in_index = 8'd7; a_in_last = 1'b0;   // in_last ignored with ACCUM_EN=0
        tick();
        chk_a("a_idx7", 1'b1, 8'h80, 4'd1, 1'b0, 1'b1);
        a_in_index = 8'd9;
        tick();
        chk_a("a_oor9", 1'b1, 8'h00, 4'd1, 1'b1, 1'b1);
        a_in_index = 8'd8;
        tick();
        chk_a("a_oor8", 1'b1, 8'h00, 4'd1, 1'b1, 1'b1);
        a_in_valid = 1'b0;
        tick();
        chk_a("a_drained", 1'b0, 8'h00, 4'd1, 1'b1, 1'b0);

        // ---------------- B: accumulate 2,5,2(last) ----------------
        b_beat(8'd2, 1'b0);
        tick();
        chk_b("b_acc1", 1'b0, 6'h00, 2'd0, 1'b0, 1'b1);
        b_beat(8'd5, 1'b0);
        tick();
        chk_b("b_acc2", 1'b0, 6'h00, 2'd0, 1'b0, 1'b1);
        b_beat(8'd2, 1'b1);
        tick();
        chk_b("b_word_24", 1'b1, 6'h24, 2'd3, 1'b0, 1'b1);
        b_in_valid = 1'b0; b_in_last = 1'b0;
        tick();
        chk_b("b_word_done", 1'b0, 6'h24, 2'd3, 1'b0, 1'b0);

        // ---------------- B: out-of-range 6 then 0x42(last) ----------------
        b_beat(8'd6, 1'b0);
        tick();
        b_beat(8'h42, 1'b1);
        tick();
        chk_b("b_oor", 1'b1, 6'h00, 2'd2, 1'b1, 1'b1);
        b_in_valid = 1'b0;
        tick();

        // ---------------- B: saturation, 5 beats ----------------
        for (int i = 0; i < 5; i++) begin
            b_beat(8'(i), (i == 4));
            tick();
        end
        chk_b("b_sat", 1'b1, 6'h1F, 2'd3, 1'b0, 1'b1);
        b_in_valid = 1'b0; b_in_last = 1'b0;
        tick();

        // ---------------- B: backpressure ----------------
        b_out_ready = 1'b0;
        b_beat(8'd1, 1'b1);
        tick();
        chk_b("b_bp_first", 1'b1, 6'h02, 2'd1, 1'b0, 1'b1);
        b_beat(8'd4, 1'b1);   // pending last beat held during the stall
        for (int i = 0; i < 4; i++) begin
            chk("b_bp_ready_low", 32'(b_in_ready), 32'd0);
            tick();
            chk_b("b_bp_hold", 1'b1, 6'h02, 2'd1, 1'b0, 1'b1);
        end
        b_out_ready = 1'b1;
        #1;
        chk("b_bp_ready_high", 32'(b_in_ready), 32'd1);
        tick();
        chk_b("b_bp_next", 1'b1, 6'h10, 2'd1, 1'b0, 1'b1);
        b_in_valid = 1'b0; b_in_last = 1'b0;
        tick();
        chk_b("b_bp_done", 1'b0, 6'h10, 2'd1, 1'b0, 1'b0);

        // ---------------- B: clear during ACC_PARTIAL ----------------
        b_beat(8'd3, 1'b0);
        tick();
        chk("b_partial_busy", 32'(b_busy), 32'd1);
        b_in_valid = 1'b0;
        b_clear = 1'b1;
        #1;
        chk("b_clear_ready", 32'(b_in_ready), 32'd0);
        tick();
        chk_b("b_cleared", 1'b0, 6'h00, 2'd0, 1'b0, 1'b0);
        b_clear = 1'b0;
        b_beat(8'd0, 1'b1);
        tick();
        chk_b("b_post_clear", 1'b1, 6'h01, 2'd1, 1'b0, 1'b1);
        b_in_valid = 1'b0; b_in_last = 1'b0;
        tick();

        // ---------------- C: NUM_DATA=1 ----------------
        c_in_valid = 1'b1; c_in_index = 8'd5; c_in_last = 1'b1;
        tick();
        chk("c_onehot", 32'(c_out_onehot), 32'd1);
        chk("c_error",  32'(c_out_error),  32'd0);
        chk("c_count",  32'(c_out_count),  32'd1);
        chk("c_valid",  32'(c_out_valid),  32'd1);
        c_in_valid = 1'b0; c_in_last = 1'b0;
        tick();

        // ---------------- B: async reset while out_valid ----------------
        b_out_ready = 1'b0;
        b_beat(8'd5, 1'b1);
        tick();
        chk_b("b_pre_reset", 1'b1, 6'h20, 2'd1, 1'b0, 1'b1);
        b_in_valid = 1'b0; b_in_last = 1'b0;
        #2;
        rstnn = 1'b0;
        #1;
        chk_b("b_async_reset", 1'b0, 6'h00, 2'd0, 1'b0, 1'b0);
        tick();
        rstnn = 1'b1;
        b_out_ready = 1'b1;
        b_beat(8'd2, 1'b1);
        tick();
        chk_b("b_fresh", 1'b1, 6'h04, 2'd1, 1'b0, 1'b1);
        b_in_valid = 1'b0; b_in_last = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
